// File: rtl/cardinal_nic_pkg.sv
// Shared constants and types for the cardinal NIC: data/address widths, register map and
// the packet type (bit 0 is the MSB, matching the processor's [0:DATA_W-1] ordering).
package cardinal_nic_pkg;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned VC_BIT = 0;

  typedef logic [0:DATA_W-1] pkt_t;
  typedef logic [ADDR_W-1:0] nic_addr_t;

  localparam nic_addr_t NIC_IN_BUF   = 2'b00;
  localparam nic_addr_t NIC_IN_STAT  = 2'b01;
  localparam nic_addr_t NIC_OUT_BUF  = 2'b10;
  localparam nic_addr_t NIC_OUT_STAT = 2'b11;

  // Status registers return the flag in the least significant (highest-index) bit.
  function automatic pkt_t flag_word(input logic flag);
    return {{(DATA_W - 1){1'b0}}, flag};
  endfunction

endpackage

// File: rtl/cardinal_nic_if.sv
// Processor-access and router-port signals of the cardinal NIC. The master modport is the
// environment (processor + router), the slave modport is the NIC itself.
interface cardinal_nic_if;
  import cardinal_nic_pkg::*;

  nic_addr_t addr_nic;
  logic      nicEn;
  logic      nicWrEn;
  pkt_t      d_in_nic;
  pkt_t      d_out_nic;
  logic      net_si;
  logic      net_ri;
  pkt_t      net_di;
  logic      net_so;
  logic      net_ro;
  pkt_t      net_do;
  logic      net_polarity;

  modport master (
    output addr_nic, nicEn, nicWrEn, d_in_nic, net_si, net_di, net_ro, net_polarity,
    input  d_out_nic, net_ri, net_so, net_do
  );

  modport slave (
    input  addr_nic, nicEn, nicWrEn, d_in_nic, net_si, net_di, net_ro, net_polarity,
    output d_out_nic, net_ri, net_so, net_do
  );

endinterface

// File: rtl/cardinal_nic_chan_buf.sv
// Channel buffer (nic_chan_buf): one or two packet slots with full flag and push/pop ports.
// A push is accepted only if not full at the start of the cycle; push and pop may coincide.
module nic_chan_buf #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  logic [0:DATA_W-1] push_data_i,
  input  logic              pop_i,
  output logic [0:DATA_W-1] head_o,
  output logic              valid_o,
  output logic              full_o
);

  localparam logic [1:0] DepthC = 2'(DEPTH);

  logic [0:DATA_W-1] mem_q [2];
  logic [1:0]        count_q, count_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic              wr_ptr, push_ok, pop_ok;

  always_comb begin
    push_ok  = push_i && (count_q < DepthC);
    pop_ok   = pop_i && (count_q != 2'd0);
    wr_ptr   = (DEPTH == 1) ? 1'b0 : (rd_ptr_q ^ count_q[0]);
    rd_ptr_d = rd_ptr_q;
    if (pop_ok && (DEPTH == 2)) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q;
    if (push_ok && !pop_ok)      count_d = count_q + 2'd1;
    else if (!push_ok && pop_ok) count_d = count_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= 2'd0;
      rd_ptr_q <= 1'b0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
    if (push_ok) mem_q[wr_ptr] <= push_data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != 2'd0);
  assign full_o  = (count_q == DepthC);

endmodule

// File: rtl/cardinal_nic.sv
// Cardinal NIC top: register decode, registered read mux and send eligibility.
// Define NIC_OUT_FIFO_EN to make the output channel a 2-entry FIFO.
module cardinal_nic
  import cardinal_nic_pkg::*;
(
  input logic           clk,
  input logic           reset,
  cardinal_nic_if.slave bus_io
);

`ifdef NIC_OUT_FIFO_EN
  localparam int unsigned OutDepth = 2;
`else
  localparam int unsigned OutDepth = 1;
`endif

  logic rd_en, wr_en, in_pop, out_push, send;
  logic in_full, in_valid, out_full, out_valid;
  pkt_t in_head, out_head;
  pkt_t d_out_q, net_do_q;
  logic net_so_q;

  assign rd_en    = bus_io.nicEn && !bus_io.nicWrEn;
  assign wr_en    = bus_io.nicEn && bus_io.nicWrEn;
  assign in_pop   = rd_en && (bus_io.addr_nic == NIC_IN_BUF) && in_valid;
  assign out_push = wr_en && (bus_io.addr_nic == NIC_OUT_BUF);
  // Only the head packet is eligible, and only on the router phase matching its VC tag.
  assign send     = out_valid && bus_io.net_ro && (out_head[VC_BIT] == bus_io.net_polarity);

  nic_chan_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (1)
  ) u_in_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (bus_io.net_si && !in_full),
    .push_data_i (bus_io.net_di),
    .pop_i       (in_pop),
    .head_o      (in_head),
    .valid_o     (in_valid),
    .full_o      (in_full)
  );

  nic_chan_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (OutDepth)
  ) u_out_buf (
    .clk         (clk),
    .reset       (reset),
    .push_i      (out_push),
    .push_data_i (bus_io.d_in_nic),
    .pop_i       (send),
    .head_o      (out_head),
    .valid_o     (out_valid),
    .full_o      (out_full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      d_out_q  <= '0;
      net_so_q <= 1'b0;
      net_do_q <= '0;
    end else begin
      net_so_q <= send;
      if (send) net_do_q <= out_head;
      if (rd_en) begin
        case (bus_io.addr_nic)
          NIC_IN_BUF:   d_out_q <= in_head;
          NIC_IN_STAT:  d_out_q <= flag_word(in_full);
          NIC_OUT_BUF:  d_out_q <= out_head;
          NIC_OUT_STAT: d_out_q <= flag_word(out_full);
          default:      d_out_q <= d_out_q;
        endcase
      end
    end
  end

  assign bus_io.net_ri    = !in_full;
  assign bus_io.d_out_nic = d_out_q;
  assign bus_io.net_so    = net_so_q;
  assign bus_io.net_do    = net_do_q;

endmodule

// File: tb/tb_cardinal_nic.sv
// Scoreboard bench for cardinal_nic: directed scenarios then random traffic, checked
// against a queue-based model of the two channels.
module tb_cardinal_nic;
  import cardinal_nic_pkg::*;

`ifdef NIC_OUT_FIFO_EN
  localparam int OutCap = 2;
`else
  localparam int OutCap = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  cardinal_nic_if bus ();

  cardinal_nic dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  pkt_t in_q[$];
  pkt_t out_q[$];
  pkt_t exp_send[$];
  pkt_t exp_rd[$];
  pkt_t last_in;
  bit   in_known;
  int   checks = 0;
  int   failures = 0;
  logic ro_v, pol_v;
  logic rd_seen = 1'b0;

  task automatic check(input string name, input pkt_t act, input pkt_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) rd_seen <= bus.nicEn & ~bus.nicWrEn & ~reset;

  always @(negedge clk) begin
    if (rd_seen) begin
      if (exp_rd.size() == 0) begin
        checks++; failures++;
        $display("FAIL rd_unexpected actual=%h required=none", bus.d_out_nic);
      end else begin
        check("rd_data", bus.d_out_nic, exp_rd.pop_front());
      end
    end
    if (bus.net_so !== 1'b0) begin
      if (exp_send.size() == 0) begin
        checks++; failures++;
        $display("FAIL spurious_send actual=%b/%h required=no pulse", bus.net_so, bus.net_do);
      end else begin
        check("send_data", bus.net_do, exp_send.pop_front());
      end
    end
  end

  // Drive one cycle of inputs, apply the model's view of the coming edge, then check net_ri.
  task automatic step(input logic rst, input logic en, input logic wr, input logic [1:0] addr,
                      input pkt_t d, input logic si, input pkt_t di);
    pkt_t rv;
    bit   snd, acc, arr;
    reset = rst; bus.nicEn = en; bus.nicWrEn = wr; bus.addr_nic = addr; bus.d_in_nic = d;
    bus.net_si = si; bus.net_di = di; bus.net_ro = ro_v; bus.net_polarity = pol_v;
    if (rst) begin
      in_q.delete(); out_q.delete(); in_known = 0;
    end else begin
      snd = (out_q.size() > 0) && ro_v && (out_q[0][VC_BIT] == pol_v);
      acc = en && wr && (addr == 2'b10) && (out_q.size() < OutCap);
      arr = si && (in_q.size() == 0);
      if (en && !wr) begin
        case (addr)
          2'b00: begin
            rv = (in_q.size() > 0) ? in_q[0] : last_in;
            if (in_q.size() > 0) void'(in_q.pop_front());
          end
          2'b01:   rv = pkt_t'(in_q.size() != 0);
          2'b10:   rv = out_q[0];
          default: rv = pkt_t'(out_q.size() == OutCap);
        endcase
        exp_rd.push_back(rv);
      end
      if (snd) exp_send.push_back(out_q.pop_front());
      if (acc) out_q.push_back(d);
      if (arr) begin in_q.push_back(di); last_in = di; in_known = 1; end
    end
    @(posedge clk); #1;
    check("net_ri", pkt_t'(bus.net_ri), pkt_t'(in_q.size() == 0));
    if (rst) begin
      check("rst_d_out", bus.d_out_nic, '0);
      check("rst_net_so", pkt_t'(bus.net_so), '0);
      check("rst_net_do", bus.net_do, '0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 2'b00, '0, 0, '0);
  endtask

  task automatic rd(input logic [1:0] addr);
    step(0, 1, 0, addr, '0, 0, '0);
  endtask

  task automatic wr(input pkt_t d);
    step(0, 1, 1, 2'b10, d, 0, '0);
  endtask

  initial begin
    logic       r_rst, r_en, r_wr, r_si;
    logic [1:0] r_addr;
    ro_v = 0; pol_v = 0; reset = 1;
    bus.nicEn = 0; bus.nicWrEn = 0; bus.addr_nic = 2'b00; bus.d_in_nic = '0;
    bus.net_si = 0; bus.net_di = '0; bus.net_ro = 0; bus.net_polarity = 0;

    step(1, 0, 0, 2'b00, '0, 0, '0);
    step(1, 0, 0, 2'b00, '0, 0, '0);
    rd(2'b11); rd(2'b01);

    step(0, 0, 0, 2'b00, '0, 1, 64'hDEAD_BEEF_0000_0001);
    rd(2'b01); rd(2'b00); rd(2'b01); rd(2'b00);

    ro_v = 1; pol_v = 0;
    wr(64'h8000_0000_0000_00AA);
    idle(3); rd(2'b11); rd(2'b10);
    pol_v = 1; idle(3);

    ro_v = 0;
    wr(64'h0123_4567_89AB_CDEF);
    wr(64'h0FED_CBA9_8765_4321);
    idle(2); ro_v = 1; pol_v = 0; idle(4);

    ro_v = 0;
    wr(64'h8111_2222_3333_4444);
    step(0, 0, 0, 2'b00, '0, 1, 64'h5555_6666_7777_8888);
    rd(2'b11);
    step(1, 0, 0, 2'b00, '0, 0, '0);
    ro_v = 1; pol_v = 1; idle(2); pol_v = 0; idle(2);
    rd(2'b01); rd(2'b11);

    for (int i = 0; i < 12; i++)
      step(0, (i % 3) == 2, 0, 2'b00, '0, 1, pkt_t'(64'hC0DE_0000_0000_0000 | i));
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      r_rst  = ($urandom_range(0, 199) == 0);
      r_en   = $urandom_range(0, 1);
      r_wr   = $urandom_range(0, 1);
      r_addr = 2'($urandom_range(0, 3));
      r_si   = ($urandom_range(0, 2) == 0);
      ro_v   = $urandom_range(0, 1);
      pol_v  = $urandom_range(0, 1);
      if (r_en && !r_wr && ((r_addr == 2'b00 && in_q.size() == 0 && !in_known) ||
                            (r_addr == 2'b10 && out_q.size() == 0)))
        r_addr = 2'b01;
      if (r_en && r_wr && ($urandom_range(0, 3) != 0)) r_addr = 2'b10;
      step(r_rst, r_en, r_wr, r_addr, pkt_t'({$urandom, $urandom}), r_si,
           pkt_t'({$urandom, $urandom}));
    end

    ro_v = 0; idle(3);
    check("send_drain", pkt_t'(exp_send.size()), '0);
    check("rd_drain", pkt_t'(exp_rd.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
